mac_array_cfg: RTL and testbench

//  Parametrised successor array of bw x bw MAC PEs (row x col) with per-row instruction skew and two dataflows:

---
 rtl/mac_array_cfg.sv | 164 ++++++++++++++++
 tb/tb_mac_array_cfg.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mac_array_cfg.sv
// mac_array_cfg: row x col array of MAC PEs, weight- or output-stationary.
// Instructions enter at PE(0,0) and skew one register per row and per column.
module mac_array_cfg #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int row     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mode,
    input  logic [2:0]             inst_w,
    input  logic [row*bw-1:0]      in_w,
    input  logic [psum_bw*col-1:0] in_n,
    output logic [psum_bw*col-1:0] out_s,
    output logic [col-1:0]         valid,
    output logic                   busy,
    output logic                   mode_q
);

    logic [2:0]         r_inst [row][col];
    logic [bw-1:0]      r_act  [row][col];
    logic [bw-1:0]      r_wgt  [row][col];
    logic [bw-1:0]      r_wfwd [row][col];
    logic [psum_bw-1:0] r_acc  [row][col];
    logic [psum_bw-1:0] r_psum [row][col];
    logic               r_lrdy [row][col];
    logic [col-1:0]     r_valid;
    logic               r_mode;

    logic [2:0]         w_inst_pri;
    logic [2:0]         w_iin  [row][col];
    logic [2:0]         w_fwd  [row][col];
    logic [bw-1:0]      w_a    [row][col];
    logic [bw-1:0]      w_wn   [row][col];
    logic [bw-1:0]      w_wt   [row][col];
    logic [psum_bw-1:0] w_pin  [row][col];
    logic [psum_bw-1:0] w_prod [row][col];
    logic               w_cap  [row][col];
    logic               w_busy;

    always_comb begin
        w_inst_pri = 3'b000;
        if (inst_w[2]) begin
            w_inst_pri = 3'b100;
        end else if (inst_w[1]) begin
            w_inst_pri = 3'b010;
        end else if (inst_w[0]) begin
            w_inst_pri = 3'b001;
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int r = 0; r < row; r++) begin
            for (int c = 0; c < col; c++) begin
                w_busy = w_busy | (|r_inst[r][c]);
            end
        end
    end

    generate
        for (genvar r = 0; r < row; r++) begin : g_row
            for (genvar c = 0; c < col; c++) begin : g_col
                if (c == 0) begin : g_west_edge
                    assign w_a[r][c] = in_w[r*bw +: bw];
                end else begin : g_west_pe
                    assign w_a[r][c] = r_act[r][c-1];
                end

                if (r == 0) begin : g_north_edge
                    assign w_wn[r][c]  = in_n[c*psum_bw +: bw];
                    assign w_pin[r][c] = in_n[c*psum_bw +: psum_bw];
                end else begin : g_north_pe
                    assign w_wn[r][c]  = r_wfwd[r-1][c];
                    assign w_pin[r][c] = r_psum[r-1][c];
                end

                // Column 0 takes the unmasked row-above inst, so every row sees each load.
                if (r == 0 && c == 0) begin : g_inst_origin
                    assign w_iin[r][c] = w_inst_pri;
                end else if (c == 0) begin : g_inst_down
                    assign w_iin[r][c] = r_inst[r-1][0];
                end else begin : g_inst_east
                    assign w_iin[r][c] = w_fwd[r][c-1];
                end

                // A PE that captures a weight consumes the load instead of passing it on.
                assign w_cap[r][c] = r_inst[r][c][0] & ~r_mode & r_lrdy[r][c];
                assign w_fwd[r][c] = {r_inst[r][c][2:1],
                                      r_inst[r][c][0] & ~w_cap[r][c]};

                assign w_wt[r][c] = r_mode ? w_wn[r][c] : r_wgt[r][c];
                assign w_prod[r][c] =
                    {{(psum_bw-bw){1'b0}}, w_a[r][c]} *
                    {{(psum_bw-bw){w_wt[r][c][bw-1]}}, w_wt[r][c]};
            end
        end

        for (genvar c = 0; c < col; c++) begin : g_out
            assign out_s[c*psum_bw +: psum_bw] = r_psum[row-1][c];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode  <= 1'b0;
            r_valid <= '0;
            for (int r = 0; r < row; r++) begin
                for (int c = 0; c < col; c++) begin
                    r_inst[r][c] <= '0;
                    r_act[r][c]  <= '0;
                    r_wgt[r][c]  <= '0;
                    r_wfwd[r][c] <= '0;
                    r_acc[r][c]  <= '0;
                    r_psum[r][c] <= '0;
                    r_lrdy[r][c] <= 1'b1;
                end
            end
        end else begin
            if (!w_busy && inst_w == 3'b000) begin
                r_mode <= mode;
            end
            for (int r = 0; r < row; r++) begin
                for (int c = 0; c < col; c++) begin
                    r_inst[r][c] <= w_iin[r][c];
                    if (!r_mode) begin
                        if (r_inst[r][c][0]) begin
                            if (r_lrdy[r][c]) begin
                                r_wgt[r][c]  <= w_a[r][c];
                                r_lrdy[r][c] <= 1'b0;
                            end else begin
                                r_act[r][c] <= w_a[r][c];
                            end
                        end
                        if (r_inst[r][c][1]) begin
                            r_psum[r][c] <= w_pin[r][c] + w_prod[r][c];
                            r_act[r][c]  <= w_a[r][c];
                        end
                    end else begin
                        if (r_inst[r][c][1]) begin
                            r_acc[r][c]  <= r_acc[r][c] + w_prod[r][c];
                            r_act[r][c]  <= w_a[r][c];
                            r_wfwd[r][c] <= w_wn[r][c];
                        end
                        if (r_inst[r][c][2]) begin
                            r_psum[r][c] <= r_acc[r][c];
                            r_acc[r][c]  <= w_pin[r][c];
                        end
                    end
                end
            end
            for (int c = 0; c < col; c++) begin
                r_valid[c] <= r_mode ? r_inst[row-1][c][2]
                                     : r_inst[row-1][c][1];
            end
        end
    end

    assign valid  = r_valid;
    assign busy   = w_busy;
    assign mode_q = r_mode;

endmodule

// File: tb/tb_mac_array_cfg.sv
// tb_mac_array_cfg: directed checks of a 2x2 mac_array_cfg in WS and OS modes.
// Row operands are pre-skewed by hand; expected values are hand-computed.
module tb_mac_array_cfg;

    localparam int BW   = 4;
    localparam int PSBW = 16;
    localparam int COL  = 2;
    localparam int ROW  = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                mode;
    logic [2:0]          inst_w;
    logic [ROW*BW-1:0]   in_w;
    logic [PSBW*COL-1:0] in_n;
    logic [PSBW*COL-1:0] out_s;
    logic [COL-1:0]      valid;
    logic                busy;
    logic                mode_q;

    int n_chk  = 0;
    int n_pass = 0;

    mac_array_cfg #(
        .bw(BW), .psum_bw(PSBW), .col(COL), .row(ROW)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .inst_w(inst_w),
        .in_w(in_w), .in_n(in_n), .out_s(out_s), .valid(valid),
        .busy(busy), .mode_q(mode_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input logic [2:0] i, input logic [7:0] w);
        inst_w = i;
        in_w   = w;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] os(input int k);
        return {16'h0000, out_s[k*PSBW +: PSBW]};
    endfunction

    initial begin
        reset  = 1'b1;
        mode   = 1'b0;
        inst_w = 3'b010;
        in_w   = '0;
        in_n   = '0;

        // reset with execute held
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_out", out_s, 32'h0);
        chk("rst_valid", valid, 32'h0);
        chk("rst_busy", busy, 32'h0);
        chk("rst_mode", mode_q, 32'h0);
        reset = 1'b0;
        step(3'b000, 8'h00);
        chk("post_rst_out", out_s, 32'h0);
        chk("post_rst_valid", valid, 32'h0);
        chk("post_rst_busy", busy, 32'h0);

        // WS 2x2: weights row0 {3,-2}, row1 {1,4}; acts 5,2
        step(3'b001, 8'h00);
        step(3'b001, 8'h03);
        step(3'b010, 8'h1E);
        step(3'b000, 8'h45);
        chk("ws_busy_mid", busy, 32'h1);
        chk("ws_valid_early", valid, 32'h0);
        step(3'b000, 8'h20);
        chk("ws_col0", os(0), 32'h0011);
        chk("ws_valid0", valid, 32'h1);
        step(3'b000, 8'h00);
        chk("ws_col1", os(1), 32'hFFFE);
        chk("ws_valid1", valid, 32'h2);
        chk("ws_col0_hold", os(0), 32'h0011);
        chk("ws_busy_done", busy, 32'h0);

        // mode request while busy is ignored
        mode = 1'b1;
        step(3'b010, 8'h00);
        chk("mode_inst", mode_q, 32'h0);
        chk("mode_busy1", busy, 32'h1);
        step(3'b000, 8'h00);
        chk("mode_busy", mode_q, 32'h0);
        step(3'b000, 8'h00);
        step(3'b000, 8'h00);
        chk("mode_still0", mode_q, 32'h0);
        chk("mode_idle_busy", busy, 32'h0);
        step(3'b000, 8'h00);
        chk("mode_taken", mode_q, 32'h1);

        // OS 2x2: three executes, act=1, w=2
        in_n = {16'd2, 16'd2};
        step(3'b010, 8'h11);
        step(3'b010, 8'h11);
        step(3'b010, 8'h11);
        chk("os_exec_valid", valid, 32'h0);
        step(3'b000, 8'h11);
        step(3'b000, 8'h11);
        step(3'b000, 8'h11);
        chk("os_exec_busy", busy, 32'h0);
        chk("os_exec_valid2", valid, 32'h0);
        in_n = '0;
        step(3'b110, 8'h00);
        step(3'b100, 8'h00);
        step(3'b000, 8'h00);
        chk("os_d1_col0", os(0), 32'h6);
        chk("os_d1_valid", valid, 32'h1);
        step(3'b000, 8'h00);
        chk("os_d2_col0", os(0), 32'h6);
        chk("os_d2_col1", os(1), 32'h6);
        chk("os_d2_valid", valid, 32'h3);
        step(3'b000, 8'h00);
        chk("os_d3_col1", os(1), 32'h6);
        chk("os_d3_valid", valid, 32'h2);
        step(3'b000, 8'h00);
        chk("os_d4_valid", valid, 32'h0);
        chk("os_d4_busy", busy, 32'h0);
        // second drain pair shows accumulators left at zero
        step(3'b100, 8'h00);
        step(3'b100, 8'h00);
        step(3'b000, 8'h00);
        chk("os_z_col0", os(0), 32'h0);
        chk("os_z_valid", valid, 32'h1);
        step(3'b000, 8'h00);
        chk("os_z_col1", os(1), 32'h0);
        chk("os_z_valid2", valid, 32'h3);
        step(3'b000, 8'h00);
        step(3'b000, 8'h00);

        // reset in the middle of an OS accumulate
        in_n = {16'd2, 16'd2};
        step(3'b010, 8'h11);
        step(3'b010, 8'h11);
        reset = 1'b1;
        step(3'b010, 8'h11);
        chk("mid_rst_busy", busy, 32'h0);
        chk("mid_rst_valid", valid, 32'h0);
        chk("mid_rst_mode", mode_q, 32'h0);
        chk("mid_rst_out", out_s, 32'h0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(3'b000, 8'h00);
            chk("mid_rst_novalid", valid, 32'h0);
        end
        chk("mid_rst_mode_back", mode_q, 32'h1);
        in_n = '0;
        step(3'b100, 8'h00);
        step(3'b100, 8'h00);
        step(3'b000, 8'h00);
        chk("mid_rst_acc1", os(0), 32'h0);
        chk("mid_rst_dvalid", valid, 32'h1);
        step(3'b000, 8'h00);
        chk("mid_rst_acc0", os(0), 32'h0);
        chk("mid_rst_acc_c1", os(1), 32'h0);

        // WS wrap: row0 weights {7,-8}, row1 {0,0}, act 15
        reset = 1'b1;
        mode  = 1'b0;
        step(3'b000, 8'h00);
        reset = 1'b0;
        step(3'b000, 8'h00);
        chk("ovf_mode", mode_q, 32'h0);
        in_n = {16'h0000, 16'h7FFF};
        step(3'b001, 8'h00);
        step(3'b001, 8'h07);
        step(3'b010, 8'h08);
        step(3'b000, 8'h0F);
        step(3'b000, 8'h00);
        chk("ovf_wrap", os(0), 32'h8068);
        chk("ovf_valid0", valid, 32'h1);
        step(3'b000, 8'h00);
        chk("ovf_neg_w", os(1), 32'hFF88);
        chk("ovf_valid1", valid, 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
